// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a valid/ready fetch port, wait states, address faults,
// a program-load write port and a sequential clear engine. Optional macro: IMEM_PARITY_EN.

module instr_mem_ctrl #(
  parameter int  DATA_W      = 32,
  parameter int  ADDR_W      = 32,
  parameter int  DEPTH       = 1024,
  parameter int  WAIT_STATES = 0,
  parameter      INIT_FILE   = "",
  localparam int IDX_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chip_select,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_instr,
  output logic              resp_fault,
  output logic              resp_err,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  input  logic              prog_par_flip,
  input  logic              clear_start,
  output logic              busy
);

`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [3:0]        WS         = 4'(WAIT_STATES);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]    DEPTH_X    = (IDX_W + 1)'(DEPTH);
  localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W - 2)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [3:0]        wait_cnt_reg;
  logic [IDX_W-1:0]  clr_cnt_reg;
  logic [IDX_W-1:0]  req_idx_reg;
  logic              req_fault_reg;
  logic              resp_fault_reg;
  logic [MEM_W-1:0]  rd_data_reg;
  logic [MEM_W-1:0]  mem [DEPTH];

  logic [ADDR_W-3:0] req_word;
  logic [IDX_W-1:0]  req_idx;
  logic              addr_fault;
  logic              accept;
  logic              clearing;
  logic              enter_resp;
  logic              rd_fault;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_en;
  logic              prog_ok;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;

  assign req_word   = req_addr[ADDR_W-1:2];
  assign req_idx    = req_word[IDX_W-1:0];
  assign addr_fault = (req_addr[1:0] != 2'b00) || (req_word >= WORD_LIMIT);
  assign accept     = req_valid & req_ready;
  assign clearing   = (state_reg == S_CLEAR);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        // clear_start wins over a simultaneous fetch request
        if (clear_start) begin
          state_next = S_CLEAR;
        end else if (req_valid && chip_select) begin
          state_next = (WS == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_reg == LAST_IDX) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      S_IDLE:  req_ready  = chip_select & ~clear_start;
      S_RESP:  resp_valid = 1'b1;
      S_CLEAR: busy       = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // The array is read on the edge that enters RESP; with no wait states that is
  // the accept edge itself, so the live request address feeds the read.
  assign enter_resp = (state_next == S_RESP) && (state_reg != S_RESP);
  assign rd_fault   = (state_reg == S_IDLE) ? addr_fault : req_fault_reg;
  assign rd_idx     = (state_reg == S_IDLE) ? req_idx : req_idx_reg;
  assign rd_en      = enter_resp & ~rd_fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_reg   <= 4'd0;
      clr_cnt_reg    <= '0;
      req_idx_reg    <= '0;
      req_fault_reg  <= 1'b0;
      resp_fault_reg <= 1'b0;
    end else begin
      if (accept) begin
        req_idx_reg   <= req_idx;
        req_fault_reg <= addr_fault;
        wait_cnt_reg  <= WS - 4'd1;
      end else if ((state_reg == S_WAIT) && (wait_cnt_reg != 4'd0)) begin
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      end
      if (enter_resp) begin
        resp_fault_reg <= rd_fault;
      end
      if (clearing) begin
        clr_cnt_reg <= (clr_cnt_reg == LAST_IDX) ? '0 : clr_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- array
  assign prog_ok   = prog_we && ({1'b0, prog_addr} < DEPTH_X) && !clearing;
  assign mem_we    = clearing | prog_ok;
  assign mem_waddr = clearing ? clr_cnt_reg : prog_addr;

`ifdef IMEM_PARITY_EN
  assign mem_wdata = clearing ? '0 : {(^prog_wdata) ^ prog_par_flip, prog_wdata};
`else
  assign mem_wdata = clearing ? '0 : prog_wdata;
`endif

  // Write and read share one block so a same-word write returns the old data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_idx];
    end
  end

  // ---------------------------------------------------------------- response
  assign resp_instr = (resp_valid && !resp_fault_reg) ? rd_data_reg[DATA_W-1:0] : '0;
  assign resp_fault = resp_valid & resp_fault_reg;

`ifdef IMEM_PARITY_EN
  assign resp_err = resp_valid & ~resp_fault_reg & (^rd_data_reg);
`else
  logic unused_par_flip;
  assign unused_par_flip = prog_par_flip;
  assign resp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: a cycle-level reference model predicts
// handshakes and read data; a negedge monitor compares against the DUT.

module tb_instr_mem_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 24;
  localparam int WS     = 3;
  localparam int IDX_W  = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              chip_select;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_instr;
  logic              resp_fault;
  logic              resp_err;
  logic              prog_we;
  logic [IDX_W-1:0]  prog_addr;
  logic [DATA_W-1:0] prog_wdata;
  logic              prog_par_flip;
  logic              clear_start;
  logic              busy;

  instr_mem_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_STATES(WS), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .chip_select(chip_select),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
    .resp_fault(resp_fault), .resp_err(resp_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .prog_par_flip(prog_par_flip), .clear_start(clear_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    bit          fault;
    bit          err;
    int          acc;
  } exp_t;

  exp_t        expq[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;

  // Reference model state: word contents, planted parity errors, fetch phase, clear progress
  logic [31:0] ref_mem [DEPTH];
  bit          ref_bad [DEPTH];
  int          m_fetch      = 0;  // 0 none, 1 waiting for read, 2 responding
  int          m_read_cyc   = 0;
  int          m_clear_left = 0;
  int          m_clear_idx  = 0;
  int          m_acc        = 0;
  int          m_idx        = 0;
  bit          m_fault      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timeout waiting for DUT (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t read_model();
    exp_t e;
    e.fault = m_fault;
    e.instr = m_fault ? 32'h0 : ref_mem[m_idx];
    e.err   = PAR && !m_fault && ref_bad[m_idx];
    e.acc   = m_acc;
    return e;
  endfunction

  // Model: evaluated at each rising edge from the inputs held across that edge.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 32'h0;
      ref_bad[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_fetch      = 0;
        m_clear_left = 0;
        m_clear_idx  = 0;
        expq.delete();
      end else begin
        bit idle;
        bit clr_now;
        bit rdy;
        idle    = (m_fetch == 0) && (m_clear_left == 0);
        clr_now = (m_clear_left > 0);
        rdy     = idle && chip_select && !clear_start;
        if (m_fetch == 2 && resp_ready) m_fetch = 0;
        if (m_fetch == 1 && cyc == m_read_cyc) begin
          expq.push_back(read_model());
          m_fetch = 2;
        end
        if (rdy && req_valid) begin
          m_acc   = cyc;
          m_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= 32'(DEPTH));
          m_idx   = m_fault ? 0 : int'(req_addr >> 2);
          if (WS == 0) begin
            expq.push_back(read_model());
            m_fetch = 2;
          end else begin
            m_fetch    = 1;
            m_read_cyc = cyc + WS;
          end
        end
        if (idle && clear_start) begin
          m_clear_left = DEPTH;
          m_clear_idx  = 0;
        end
        // writes land after the read above: read-first on the same word
        if (clr_now) begin
          ref_mem[m_clear_idx] = 32'h0;
          ref_bad[m_clear_idx] = 1'b0;
          m_clear_idx++;
          m_clear_left--;
        end else if (prog_we && int'(prog_addr) < DEPTH) begin
          ref_mem[prog_addr] = prog_wdata;
          ref_bad[prog_addr] = prog_par_flip;
        end
      end
      cyc++;
    end
  end

  // Monitor: compares on the falling edge, pops the scoreboard on each handshake.
  initial begin
    bit          seen = 1'b0;
    logic [31:0] cap_instr;
    bit          cap_fault;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        seen = 1'b0;
      end else begin
        chk("req_ready", req_ready,
            (m_fetch == 0 && m_clear_left == 0 && chip_select && !clear_start) ? 1 : 0);
        chk("busy", busy, (m_clear_left > 0) ? 1 : 0);
        chk("resp_valid", resp_valid, (m_fetch == 2) ? 1 : 0);
        if (resp_valid) begin
          if (expq.size() == 0) begin
            timeout_fail("resp_unexpected");
          end else if (!seen) begin
            chk("latency", cyc - expq[0].acc, WS + 1);
            chk("resp_instr", resp_instr, expq[0].instr);
            chk("resp_fault", resp_fault, expq[0].fault);
            chk("resp_err", resp_err, expq[0].err);
            $display("fetch acc=%0d instr=%h fault=%0b err=%0b", expq[0].acc, resp_instr,
                     resp_fault, resp_err);
            cap_instr = resp_instr;
            cap_fault = resp_fault;
            seen      = 1'b1;
          end else begin
            chk("stable_instr", resp_instr, cap_instr);
            chk("stable_fault", resp_fault, cap_fault);
          end
          if (resp_ready && expq.size() > 0) begin
            void'(expq.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic prog_write(input int idx, input logic [31:0] data, input bit flip);
    prog_we       = 1'b1;
    prog_addr     = IDX_W'(idx);
    prog_wdata    = data;
    prog_par_flip = flip;
    tick();
    prog_we       = 1'b0;
    prog_par_flip = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) timeout_fail("issue");
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
  endtask

  task automatic finish_resp(input int hold);
    int n = 0;
    resp_ready = 1'b0;
    while (!resp_valid && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) timeout_fail("resp_wait");
    repeat (hold) tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input int hold);
    issue(a);
    finish_resp(hold);
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) timeout_fail("clear_wait");
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; chip_select = 1'b1; req_valid = 1'b0; req_addr = '0;
    resp_ready = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    prog_par_flip = 1'b0; clear_start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_instr", resp_instr, 0);
    chk("rst_fault", resp_fault, 0);
    chk("rst_err", resp_err, 0);

    // Clear the whole array; program writes during the clear must be dropped
    tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < DEPTH - 2; i++) begin
      prog_we    = 1'b1;
      prog_addr  = IDX_W'($urandom_range(0, DEPTH - 1));
      prog_wdata = $urandom;
      tick();
    end
    prog_we = 1'b0;
    wait_not_busy();
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 0);

    // Basic fetch, then a long back-pressure hold
    prog_write(3, 32'h00500093, 1'b0);
    fetch(32'h0000_000C, 0);
    fetch(32'h0000_000C, 5);

    // Misaligned and out-of-range addresses
    fetch(32'h0000_000E, 0);
    fetch(32'h0000_1000, 1);
    fetch(32'(DEPTH * 4), 0);
    fetch(32'(DEPTH * 4 - 4), 0);

    // Write the word being read on the read edge: old data must come back
    prog_write(5, 32'h1111_1111, 1'b0);
    issue(32'h14);
    repeat (WS - 1) tick();
    prog_write(5, 32'h2222_2222, 1'b0);
    finish_resp(0);
    fetch(32'h14, 0);

    // Out-of-range program writes are ignored
    prog_write(DEPTH + 2, 32'hDEAD_BEEF, 1'b0);

    // Parity flip and repair
    prog_write(2, 32'h0000_0013, 1'b1);
    fetch(32'h08, 0);
    prog_write(2, 32'h0000_0013, 1'b0);
    fetch(32'h08, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int kind;
      kind        = $urandom_range(0, 9);
      req_valid   = ($urandom_range(0, 1) == 1);
      if (kind == 0)      req_addr = 32'($urandom_range(0, 40) * 4 + $urandom_range(1, 3));
      else if (kind == 1) req_addr = 32'($urandom_range(DEPTH, 300) * 4);
      else                req_addr = 32'($urandom_range(0, 7) * 4);
      resp_ready    = ($urandom_range(0, 2) != 0);
      chip_select   = ($urandom_range(0, 9) != 0);
      clear_start   = ($urandom_range(0, 99) == 0);
      prog_we       = ($urandom_range(0, 2) == 0);
      prog_addr     = ($urandom_range(0, 1) == 1) ? IDX_W'($urandom_range(0, 7))
                                                  : IDX_W'($urandom_range(0, 31));
      prog_wdata    = $urandom;
      prog_par_flip = ($urandom_range(0, 3) == 0);
      tick();
    end
    req_valid = 1'b0; prog_we = 1'b0; clear_start = 1'b0; chip_select = 1'b1;
    prog_par_flip = 1'b0; resp_ready = 1'b1;
    repeat (DEPTH + WS + 4) tick();
    resp_ready = 1'b0;

    // Reset in the middle of a wait, then in the middle of a clear
    prog_write(3, 32'hABCD_0003, 1'b0);
    prog_write(20, 32'h1234_5678, 1'b0);
    issue(32'h0C);
    tick();
    pulse_reset();
    fetch(32'h0C, 0);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (5) tick();
    pulse_reset();
    fetch(32'h50, 0);
    fetch(32'h0C, 0);

    // Full readback
    for (int i = 0; i < DEPTH; i++) fetch(32'(i * 4), $urandom_range(0, 2));

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
